// File: rtl/cdp1861_pkg.sv
// Shared timing constants, DMA state type and a window helper for the Pixie video controller.
// Latency: none (declarations only).
// Backpressure: none.
package cdp1861_pkg;

    localparam int CPL_DEFAULT = 14;   // machine cycles per raster line
    localparam int LPF_DEFAULT = 262;  // raster lines per frame
    localparam int DS_DEFAULT  = 80;   // first active display line
    localparam int DL_DEFAULT  = 128;  // number of active display lines
    localparam int BPL_DEFAULT = 8;    // DMA bytes fetched per active line
    localparam int VS_DEFAULT  = 4;    // vsync width in lines, from line 0

    localparam logic [1:0] SC_DMA = 2'b10;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_REQ  = 2'd1,
        DMA_DONE = 2'd2
    } dma_state_e;

    // True when v lies in [lo, lo+n).
    function automatic logic in_window(input int v, input int lo, input int n);
        return (v >= lo) && (v < lo + n);
    endfunction

endpackage

// File: rtl/cdp1861_shifter.sv
// Byte-to-pixel serialiser: 8-bit load/shift register with a 3-bit bit counter, MSB first.
// Latency: first bit on the clock after load, last bit 8 clocks after load.
// Backpressure: none; a load during an active shift restarts with the new byte.
module cdp1861_shifter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       pixel_o,
    output logic       valid_o
);

    logic [6:0] sr_q;
    logic [2:0] cnt_q;
    logic       pixel_q;
    logic       valid_q;

    // Load presents bit 7 at once; remaining bits shift out one per clock until the counter drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            pixel_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pixel_q <= data_i[7];
            sr_q    <= data_i[6:0];
            cnt_q   <= 3'd7;
            valid_q <= 1'b1;
        end else if (valid_q) begin
            if (cnt_q == 3'd0) begin
                valid_q <= 1'b0;
                pixel_q <= 1'b0;
            end else begin
                pixel_q <= sr_q[6];
                sr_q    <= {sr_q[5:0], 1'b0};
                cnt_q   <= cnt_q - 3'd1;
            end
        end
    end

    assign pixel_o = pixel_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/cdp1861.sv
// Pixie video DMA controller: raster timing, DMA-out requests, byte capture, frame flags.
// Latency: outputs registered one clock after cycle_en/strobe; pixels start 1 clock after the ack edge.
// Backpressure: a starved DMA line simply drops its unfetched bytes at the next line start.
module cdp1861
    import cdp1861_pkg::*;
#(
    parameter int CYCLES_PER_LINE = CPL_DEFAULT,
    parameter int LINES_PER_FRAME = LPF_DEFAULT,
    parameter int DISPLAY_START   = DS_DEFAULT,
    parameter int DISPLAY_LINES   = DL_DEFAULT,
    parameter int BYTES_PER_LINE  = BPL_DEFAULT,
    parameter int VSYNC_LINES     = VS_DEFAULT
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       cycle_en,
    input  logic [1:0] SC,
    input  logic [7:0] dma_data,
    input  logic       disp_on_stb,
    input  logic       disp_off_stb,
    output logic       dma_out_req,
    output logic       INT_N,
    output logic       EF1_N,
    output logic       pixel,
    output logic       pix_valid,
    output logic       hsync,
    output logic       vsync
);

    localparam int BCNT_W = $clog2(BYTES_PER_LINE + 1);

    logic [3:0]        cyc_q, cyc_d;
    logic [8:0]        line_q, line_d;
    logic              disp_en_q, disp_en_d;
    logic              active_q;
    dma_state_e        state_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic              req_q;
    logic              load_q;
    logic [7:0]        byte_q;
    logic              int_n_q, ef1_n_q, hsync_q, vsync_q;
    logic              cyc_wrap, line_start, ack;

    // Next-state of the raster counters and display enable; off strobe beats on strobe.
    always_comb begin
        cyc_wrap   = (cyc_q == 4'(CYCLES_PER_LINE - 1));
        line_start = cycle_en && cyc_wrap;
        cyc_d      = cyc_q;
        if (cycle_en) begin
            cyc_d = cyc_wrap ? 4'd0 : cyc_q + 4'd1;
        end
        line_d = line_q;
        if (line_start) begin
            line_d = (line_q == 9'(LINES_PER_FRAME - 1)) ? 9'd0 : line_q + 9'd1;
        end
        disp_en_d = disp_en_q;
        if (disp_off_stb) begin
            disp_en_d = 1'b0;
        end else if (disp_on_stb) begin
            disp_en_d = 1'b1;
        end
        ack = (state_q == DMA_REQ) && cycle_en && (SC == SC_DMA);
    end

    // Raster counters, display enable, and the per-line active flag latched at line start.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cyc_q     <= '0;
            line_q    <= '0;
            disp_en_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            cyc_q     <= cyc_d;
            line_q    <= line_d;
            disp_en_q <= disp_en_d;
            if (line_start) begin
                active_q <= disp_en_q &&
                            in_window(int'(line_d), DISPLAY_START, DISPLAY_LINES);
            end
        end
    end

    // DMA state machine: request from cycle 2 of an active line until the byte quota or line end.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= DMA_IDLE;
            req_q   <= 1'b0;
            bcnt_q  <= '0;
            load_q  <= 1'b0;
            byte_q  <= '0;
        end else begin
            load_q <= ack;
            if (ack) begin
                byte_q <= dma_data;
            end
            case (state_q)
                DMA_IDLE: begin
                    if (cycle_en && (cyc_d == 4'd2) && active_q) begin
                        state_q <= DMA_REQ;
                        req_q   <= 1'b1;
                        bcnt_q  <= '0;
                    end
                end
                DMA_REQ: begin
                    if (ack) begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                    if (line_start) begin
                        state_q <= DMA_IDLE;
                        req_q   <= 1'b0;
                    end else if (ack && (bcnt_q == BCNT_W'(BYTES_PER_LINE - 1))) begin
                        state_q <= DMA_DONE;
                        req_q   <= 1'b0;
                    end
                end
                DMA_DONE: begin
                    if (line_start) begin
                        state_q <= DMA_IDLE;
                    end
                end
                default: begin
                    state_q <= DMA_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    // Frame flags (gated by display enable) and sync pulses, decoded from next-state counters.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            int_n_q <= 1'b1;
            ef1_n_q <= 1'b1;
            hsync_q <= 1'b0;
            vsync_q <= 1'b1;
        end else begin
            int_n_q <= !(disp_en_d && in_window(int'(line_d), DISPLAY_START - 2, 2));
            ef1_n_q <= !(disp_en_d &&
                         (in_window(int'(line_d), DISPLAY_START - 4, 4) ||
                          in_window(int'(line_d), DISPLAY_START + DISPLAY_LINES - 4, 4)));
            hsync_q <= (int'(cyc_d) >= CYCLES_PER_LINE - 2);
            vsync_q <= (int'(line_d) < VSYNC_LINES);
        end
    end

    cdp1861_shifter u_shifter (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .load_i  (load_q),
        .data_i  (byte_q),
        .pixel_o (pixel),
        .valid_o (pix_valid)
    );

    assign dma_out_req = req_q;
    assign INT_N       = int_n_q;
    assign EF1_N       = ef1_n_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;

endmodule

// File: tb/tb_cdp1861.sv
// Bench for the Pixie video controller: directed phases with randomized bus traffic.
// Expected outputs come from a pulse-count based model of the raster, display and DMA rules.
// Pixel expectations are scheduled per clock index from each acknowledged byte.
module tb_cdp1861;

    localparam int CPL = 14;
    localparam int LPF = 262;
    localparam int DS  = 80;
    localparam int DL  = 128;
    localparam int BPL = 8;
    localparam int VS  = 4;

    logic       CLOCK = 1'b0;
    logic       RESET, cycle_en, disp_on_stb, disp_off_stb;
    logic [1:0] SC;
    logic [7:0] dma_data;
    logic       dma_out_req, INT_N, EF1_N, pixel, pix_valid, hsync, vsync;

    cdp1861 dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .cycle_en     (cycle_en),
        .SC           (SC),
        .dma_data     (dma_data),
        .disp_on_stb  (disp_on_stb),
        .disp_off_stb (disp_off_stb),
        .dma_out_req  (dma_out_req),
        .INT_N        (INT_N),
        .EF1_N        (EF1_N),
        .pixel        (pixel),
        .pix_valid    (pix_valid),
        .hsync        (hsync),
        .vsync        (vsync)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   m_pulses = 0;
    logic m_en     = 1'b0;
    logic m_act    = 1'b0;
    int   m_got    = 0;
    int   clk_idx  = 0;
    logic exp_pix [int];

    // Observation counters
    int   cnt_valid, cnt_rise, cnt_vs, cnt_int, cnt_ef, cnt_req, cnt_wrap, obs_acks;
    logic prev_valid = 1'b0;
    int   prev_line  = 0;
    logic obs_q [$];

    function automatic int m_cyc();
        return m_pulses % CPL;
    endfunction

    function automatic int m_line();
        return (m_pulses / CPL) % LPF;
    endfunction

    function automatic logic exp_req();
        return m_act && (m_cyc() >= 2) && (m_got < BPL);
    endfunction

    function automatic logic exp_int_n();
        return !(m_en && (m_line() == DS - 2 || m_line() == DS - 1));
    endfunction

    function automatic logic exp_ef1_n();
        int l;
        l = m_line();
        return !(m_en && ((l >= DS - 4 && l <= DS - 1) || (l >= DS + DL - 4 && l <= DS + DL - 1)));
    endfunction

    function automatic logic [7:0] byte_at(input int idx);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (idx + b < obs_q.size()) r[7-b] = obs_q[idx+b];
        end
        return r;
    endfunction

    function automatic logic [7:0] pat(input int n);
        logic [7:0] r;
        case (n)
            0:       r = 8'h81;
            1:       r = 8'h00;
            2:       r = 8'hFF;
            default: r = 8'($urandom);
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cnt_valid = 0; cnt_rise = 0; cnt_vs = 0; cnt_int = 0;
        cnt_ef = 0; cnt_req = 0; cnt_wrap = 0; obs_acks = 0;
        obs_q.delete();
    endtask

    // One clock: drive inputs, advance the model at the edge, check outputs on the falling edge.
    task automatic tick(input logic rst, input logic ce, input logic [1:0] sc,
                        input logic [7:0] d, input logic on, input logic off);
        logic old_en;
        RESET = rst; cycle_en = ce; SC = sc; dma_data = d;
        disp_on_stb = on; disp_off_stb = off;
        if (!rst && ce && sc == 2'b10 && dma_out_req) obs_acks++;
        @(posedge CLOCK);
        clk_idx++;
        if (rst) begin
            m_pulses = 0; m_en = 1'b0; m_act = 1'b0; m_got = 0;
            exp_pix.delete();
        end else begin
            if (ce && sc == 2'b10 && exp_req()) begin
                m_got++;
                for (int b = 0; b < 8; b++) exp_pix[clk_idx + 1 + b] = d[7-b];
            end
            old_en = m_en;
            if (off) m_en = 1'b0;
            else if (on) m_en = 1'b1;
            if (ce) begin
                m_pulses++;
                if (m_cyc() == 0) begin
                    m_got = 0;
                    m_act = old_en && (m_line() >= DS) && (m_line() < DS + DL);
                end
            end
        end
        @(negedge CLOCK);
        chk("dma_out_req", 32'(dma_out_req), 32'(exp_req()));
        chk("INT_N", 32'(INT_N), 32'(exp_int_n()));
        chk("EF1_N", 32'(EF1_N), 32'(exp_ef1_n()));
        chk("hsync", 32'(hsync), 32'(m_cyc() >= CPL - 2));
        chk("vsync", 32'(vsync), 32'(m_line() < VS));
        chk("pix_valid", 32'(pix_valid), 32'(exp_pix.exists(clk_idx)));
        if (exp_pix.exists(clk_idx)) begin
            chk("pixel", 32'(pixel), 32'(exp_pix[clk_idx]));
            exp_pix.delete(clk_idx);
        end
        if (pix_valid) begin
            cnt_valid++;
            obs_q.push_back(pixel);
            if (!prev_valid) cnt_rise++;
        end
        prev_valid = pix_valid;
        if (dma_out_req) cnt_req++;
        if (ce) begin
            if (vsync) cnt_vs++;
            if (!INT_N) cnt_int++;
            if (!EF1_N) cnt_ef++;
            if (dut.line_q == 9'd0 && prev_line != 0) cnt_wrap++;
            prev_line = int'(dut.line_q);
        end
    endtask

    task automatic pulse(input logic [1:0] sc, input logic [7:0] d, input int sp);
        tick(1'b0, 1'b1, sc, d, 1'b0, 1'b0);
        repeat (sp - 1) tick(1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic rand_pulse(input int sp);
        pulse(2'($urandom_range(0, 3)), 8'($urandom), sp);
    endtask

    initial begin
        int   g;
        logic req_hi;

        RESET = 1'b1; cycle_en = 1'b0; SC = 2'b00; dma_data = 8'h00;
        disp_on_stb = 1'b0; disp_off_stb = 1'b0;

        // Reset state
        tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("rst_cyc", 32'(dut.cyc_q), 32'd0);
        chk("rst_line", 32'(dut.line_q), 32'd0);

        // Both strobes together: display stays off for a whole frame
        tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1);
        clr();
        for (int i = 0; i < CPL * LPF; i++) rand_pulse(8);
        chk("off_wrap_count", 32'(cnt_wrap), 32'd1);
        chk("off_line_end", 32'(dut.line_q), 32'd0);
        chk("off_vsync_pulses", 32'(cnt_vs), 32'(VS * CPL));
        chk("off_req_clocks", 32'(cnt_req), 32'd0);
        chk("off_int_pulses", 32'(cnt_int), 32'd0);
        chk("off_ef1_pulses", 32'(cnt_ef), 32'd0);
        chk("off_valid_clocks", 32'(cnt_valid), 32'd0);

        // Display on, run to the start of the first active line
        tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        clr();
        g = 0;
        while (m_line() != DS && g < CPL * LPF) begin
            rand_pulse(8);
            g++;
        end
        chk("reach_line80", 32'(dut.line_q), 32'(DS));
        chk("int_low_pulses", 32'(cnt_int), 32'(2 * CPL));
        chk("ef1_low_pulses_top", 32'(cnt_ef), 32'(4 * CPL));
        chk("pre_active_req", 32'(cnt_req), 32'd0);

        // Line 80: CPU acks every machine cycle
        clr();
        for (int i = 0; i < CPL; i++) pulse(2'b10, pat(m_got), 8);
        chk("full_acks", 32'(obs_acks), 32'(BPL));
        chk("full_valid_clocks", 32'(cnt_valid), 32'(BPL * 8));
        chk("full_gapless", 32'(cnt_rise), 32'd1);
        chk("full_byte0", 32'(byte_at(0)), 32'h81);
        chk("full_byte1", 32'(byte_at(8)), 32'h00);
        chk("full_byte2", 32'(byte_at(16)), 32'hFF);

        // Line 81: CPU starves the DMA after 5 bytes
        clr();
        req_hi = 1'b0;
        for (int i = 0; i < CPL; i++) begin
            pulse((obs_acks < 5) ? 2'b10 : 2'b00, 8'($urandom), 8);
            if (i == CPL - 2) req_hi = dma_out_req;
        end
        chk("starve_acks", 32'(obs_acks), 32'd5);
        chk("starve_valid_clocks", 32'(cnt_valid), 32'd40);
        chk("starve_req_held", 32'(req_hi), 32'd1);
        chk("starve_req_drop", 32'(dma_out_req), 32'd0);

        // Line 82 requests afresh at cycle 2
        pulse(2'b00, 8'h00, 8);
        pulse(2'b00, 8'h00, 8);
        chk("req_again_cyc2", 32'(dma_out_req), 32'd1);

        // Random traffic to the end of the active window
        clr();
        g = 0;
        while (m_line() != DS + DL && g < CPL * LPF) begin
            rand_pulse((m_line() < 90) ? int'($urandom_range(8, 10)) : 8);
            g++;
        end
        chk("ef1_low_pulses_bottom", 32'(cnt_ef), 32'(4 * CPL));
        chk("int_low_bottom", 32'(cnt_int), 32'd0);

        // Into the next frame: reset in the middle of a byte on line 100
        g = 0;
        while (!(m_line() == 100 && m_cyc() == 2) && g < CPL * LPF) begin
            rand_pulse(8);
            g++;
        end
        chk("reach_line100", 32'(dut.line_q), 32'd100);
        tick(1'b0, 1'b1, 2'b10, 8'hA5, 1'b0, 1'b0);
        repeat (3) tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("pre_reset_valid", 32'(pix_valid), 32'd1);
        tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("mid_rst_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_req", 32'(dma_out_req), 32'd0);
        chk("mid_rst_cyc", 32'(dut.cyc_q), 32'd0);
        chk("mid_rst_line", 32'(dut.line_q), 32'd0);
        repeat (4) rand_pulse(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
